// File: rtl/digit_disp_pkg.sv
// ============================================================================
// digit_disp_pkg : shared types and constants for the product digit display
// Rev 1.0
// ============================================================================
`default_nettype none

package digit_disp_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int WIN_DIGITS = 3;
  // One window position per possible offset of the 3-digit view.
  localparam int NUM_POS    = NUM_DIGITS - WIN_DIGITS + 1;

  typedef logic [1:0] win_sel_t;

  typedef enum logic [1:0] {
    WIN_HOLD  = 2'd0,
    WIN_CLEAR = 2'd1,
    WIN_INC   = 2'd2,
    WIN_DEC   = 2'd3
  } win_op_t;

endpackage

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// btn_conditioner : synchroniser, debounce, press edge detect, auto-repeat
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_conditioner #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic step
);

  localparam int            DW       = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic          deb_dly_q, deb_dly_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          press;

  // The level is accepted only after DEB_CYCLES consecutive mismatching samples.
  always_comb begin
    sync_d    = {sync_q[0], btn_raw};
    deb_d     = deb_q;
    cnt_d     = '0;
    deb_dly_d = deb_q;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign press = deb_q & ~deb_dly_q;

  generate
    if (REPEAT_CYCLES > 0) begin : g_repeat
      localparam int            RW       = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

      logic [RW-1:0] rep_q, rep_d;

      // Phase counter is zero in the press cycle, so repeats land on multiples of the period.
      always_comb begin
        rep_d = '0;
        if (deb_q && (rep_q != REP_LAST)) begin
          rep_d = rep_q + RW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rep_q <= '0;
        end else begin
          rep_q <= rep_d;
        end
      end

      assign step = press | (deb_q & deb_dly_q & (rep_q == '0));
    end else begin : g_no_repeat
      assign step = press;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/digit_window_ctrl.sv
// ============================================================================
// digit_window_ctrl : scroll buttons to saturating 3-of-5 digit window index
// Rev 1.0
// ============================================================================
`default_nettype none

module digit_window_ctrl
  import digit_disp_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 0,
  parameter int NUM_POS       = digit_disp_pkg::NUM_POS
) (
  input  logic     clk,
  input  logic     R_n,
  input  logic     btn_left,
  input  logic     btn_right,
  input  logic     prod_valid,
  output win_sel_t win_sel,
  output logic     step_left,
  output logic     step_right,
  output logic     at_min,
  output logic     at_max
);

  localparam win_sel_t WIN_MAX = win_sel_t'(NUM_POS - 1);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;
  logic       step_l, step_r;
  logic       pv_q, pv_d;
  logic       pv_rise;
  win_sel_t   win_q, win_d;
  win_op_t    win_op;

  // Assertion stays asynchronous; only the release is aligned to clk.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_int = rst_sync_q[1];

  btn_conditioner #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_btn_left (
    .clk    (clk),
    .rst_n  (rst_n_int),
    .btn_raw(btn_left),
    .step   (step_l)
  );

  btn_conditioner #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_btn_right (
    .clk    (clk),
    .rst_n  (rst_n_int),
    .btn_raw(btn_right),
    .step   (step_r)
  );

  assign pv_rise = prod_valid & ~pv_q;

  always_comb begin
    pv_d   = prod_valid;
    win_op = WIN_HOLD;
    if (pv_rise) begin
      win_op = WIN_CLEAR;
    end else if (step_l && step_r) begin
      win_op = WIN_HOLD;
    end else if (step_l && (win_q != WIN_MAX)) begin
      win_op = WIN_INC;
    end else if (step_r && (win_q != '0)) begin
      win_op = WIN_DEC;
    end

    win_d = win_q;
    case (win_op)
      WIN_CLEAR: win_d = '0;
      WIN_INC:   win_d = win_q + win_sel_t'(1);
      WIN_DEC:   win_d = win_q - win_sel_t'(1);
      default:   win_d = win_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pv_q  <= 1'b0;
      win_q <= '0;
    end else begin
      pv_q  <= pv_d;
      win_q <= win_d;
    end
  end

  assign win_sel    = win_q;
  assign step_left  = step_l;
  assign step_right = step_r;
  assign at_min     = (win_q == '0);
  assign at_max     = (win_q == WIN_MAX);

endmodule

`default_nettype wire

// File: tb/tb_digit_window_ctrl.sv
// ============================================================================
// tb_digit_window_ctrl : directed plus random scroll stimulus, two repeat settings
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_digit_window_ctrl;

  localparam int DEB  = 4;
  localparam int MAXC = 8192;
  localparam int TOP  = 2;

  logic       clk = 1'b0;
  logic       R_n, btn_left, btn_right, prod_valid;
  logic [1:0] win0, win1;
  logic       sl0, sr0, amin0, amax0;
  logic       sl1, sr1, amin1, amax1;

  always #5 clk = ~clk;

  digit_window_ctrl #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(0), .NUM_POS(3)) dut0 (
    .clk(clk), .R_n(R_n), .btn_left(btn_left), .btn_right(btn_right),
    .prod_valid(prod_valid), .win_sel(win0), .step_left(sl0),
    .step_right(sr0), .at_min(amin0), .at_max(amax0)
  );

  digit_window_ctrl #(.DEB_CYCLES(DEB), .REPEAT_CYCLES(8), .NUM_POS(3)) dut1 (
    .clk(clk), .R_n(R_n), .btn_left(btn_left), .btn_right(btn_right),
    .prod_valid(prod_valid), .win_sel(win1), .step_left(sl1),
    .step_right(sr1), .at_min(amin1), .at_max(amax1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Input history indexed by the edge after which each value was driven.
  bit hist [3][MAXC];
  bit m_deb   [2];
  int m_press [2];
  bit m_pulse [2][2];
  int m_win   [2];

  int n_sl [2];
  int n_sr [2];
  int n_both0;
  int sr1_stamp [$];

  int  s_l0, s_r0, s_l1, s_r1, s_b0;
  bit  found;
  int  rl, rr, rp;
  bit  seq [19];

  function automatic bit hget(input int s, input int i);
    if (i < 0 || i >= MAXC) return 1'b0;
    return hist[s][i];
  endfunction

  function automatic int rep_of(input int d);
    return (d == 0) ? 0 : 8;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i <= cyc && i < MAXC; i++) hist[s][i] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_deb[b]   = 1'b0;
      m_press[b] = 0;
      for (int d = 0; d < 2; d++) m_pulse[d][b] = 1'b0;
    end
    m_win[0] = 0;
    m_win[1] = 0;
  endtask

  // Button level at the synchroniser output before edge e is the raw value driven after edge e-3.
  task automatic model_step();
    int e;
    bit pvr, all_diff, rose;
    e   = cyc;
    pvr = hget(2, e - 1) && !hget(2, e - 2);
    for (int d = 0; d < 2; d++) begin
      if (pvr) m_win[d] = 0;
      else if (!(m_pulse[d][0] && m_pulse[d][1])) begin
        if (m_pulse[d][0])      m_win[d] = (m_win[d] < TOP) ? m_win[d] + 1 : TOP;
        else if (m_pulse[d][1]) m_win[d] = (m_win[d] > 0) ? m_win[d] - 1 : 0;
      end
    end
    for (int b = 0; b < 2; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hget(b, e - 3 - j) == m_deb[b]) all_diff = 1'b0;
      rose = 1'b0;
      if (all_diff) begin
        m_deb[b] = !m_deb[b];
        if (m_deb[b]) begin
          rose       = 1'b1;
          m_press[b] = e;
        end
      end
      for (int d = 0; d < 2; d++)
        m_pulse[d][b] = m_deb[b] &&
          (rose || (rep_of(d) > 0 && ((e - m_press[b]) % rep_of(d)) == 0));
    end
  endtask

  task automatic check_outputs();
    chk("win_sel0",    {6'd0, win0},  8'(m_win[0]));
    chk("step_left0",  {7'd0, sl0},   {7'd0, m_pulse[0][0]});
    chk("step_right0", {7'd0, sr0},   {7'd0, m_pulse[0][1]});
    chk("at_min0",     {7'd0, amin0}, {7'd0, m_win[0] == 0});
    chk("at_max0",     {7'd0, amax0}, {7'd0, m_win[0] == TOP});
    chk("win_sel1",    {6'd0, win1},  8'(m_win[1]));
    chk("step_left1",  {7'd0, sl1},   {7'd0, m_pulse[1][0]});
    chk("step_right1", {7'd0, sr1},   {7'd0, m_pulse[1][1]});
    chk("at_min1",     {7'd0, amin1}, {7'd0, m_win[1] == 0});
    chk("at_max1",     {7'd0, amax1}, {7'd0, m_win[1] == TOP});
    if (sl0 === 1'b1) n_sl[0]++;
    if (sr0 === 1'b1) n_sr[0]++;
    if (sl1 === 1'b1) n_sl[1]++;
    if (sr1 === 1'b1) begin
      n_sr[1]++;
      sr1_stamp.push_back(cyc);
    end
    if (sl0 === 1'b1 && sr0 === 1'b1) n_both0++;
  endtask

  task automatic tick();
    if (cyc < MAXC) begin
      hist[0][cyc] = btn_left;
      hist[1][cyc] = btn_right;
      hist[2][cyc] = prod_valid;
    end
    @(posedge clk);
    cyc++;
    #1;
    model_step();
    check_outputs();
  endtask

  task automatic press(input int which, input int hold, input int gap);
    if (which != 1) btn_left  = 1'b1;
    if (which != 0) btn_right = 1'b1;
    repeat (hold) tick();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic snap();
    s_l0 = n_sl[0]; s_r0 = n_sr[0]; s_l1 = n_sl[1]; s_r1 = n_sr[1]; s_b0 = n_both0;
  endtask

  function automatic int pick(input int lo_short, input int hi_long);
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                       : int'($urandom_range(lo_short, hi_long));
  endfunction

  initial begin
    R_n = 1'b0; btn_left = 1'b0; btn_right = 1'b0; prod_valid = 1'b0;
    n_sl = '{0, 0}; n_sr = '{0, 0}; n_both0 = 0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    repeat (2) tick();
    chk("reset_win_sel", {6'd0, win0}, 8'd0);
    chk("reset_at_min",  {7'd0, amin0}, 8'd1);
    chk("reset_at_max",  {7'd0, amax0}, 8'd0);

    R_n = 1'b1;
    repeat (22) tick();
    chk("idle_no_steps", 8'(n_sl[0] + n_sr[0] + n_sl[1] + n_sr[1]), 8'd0);
    chk("idle_win_sel",  {6'd0, win0}, 8'd0);

    press(0, 10, 10);
    chk("left1_win_sel", {6'd0, win0}, 8'd1);
    press(0, 10, 10);
    chk("left2_win_sel", {6'd0, win0}, 8'd2);
    chk("left2_at_max",  {7'd0, amax0}, 8'd1);
    press(0, 10, 10);
    chk("left3_saturated", {6'd0, win0}, 8'd2);
    chk("left3_pulse_count", 8'(n_sl[0]), 8'd3);

    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    repeat (3) tick();
    chk("pv_clear_win_sel", {6'd0, win0}, 8'd0);

    snap();
    seq = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    foreach (seq[i]) begin
      btn_left = seq[i];
      tick();
    end
    btn_left = 1'b0;
    repeat (12) tick();
    chk("bounce_one_pulse", 8'(n_sl[0] - s_l0), 8'd1);
    chk("bounce_win_sel",   {6'd0, win0}, 8'd1);

    snap();
    press(0, 3, 12);
    chk("glitch_no_pulse", 8'(n_sl[0] - s_l0), 8'd0);
    chk("glitch_win_sel",  {6'd0, win0}, 8'd1);

    snap();
    press(2, 10, 10);
    chk("both_left_pulse",  8'(n_sl[0] - s_l0), 8'd1);
    chk("both_right_pulse", 8'(n_sr[0] - s_r0), 8'd1);
    chk("both_same_cycle",  8'(n_both0 - s_b0), 8'd1);
    chk("both_win_sel",     {6'd0, win0}, 8'd1);

    press(0, 10, 10);
    chk("pre_pv_win_sel", {6'd0, win0}, 8'd2);
    btn_right = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (m_pulse[0][1]) found = 1'b1;
    end
    chk("pv_wait_right_pulse", {7'd0, found}, 8'd1);
    prod_valid = 1'b1;
    tick();
    chk("pv_override_win_sel", {6'd0, win0}, 8'd0);
    chk("pv_override_at_min",  {7'd0, amin0}, 8'd1);
    btn_right = 1'b0;
    repeat (12) tick();
    prod_valid = 1'b0;
    repeat (3) tick();

    press(0, 20, 10);
    press(0, 20, 10);
    chk("rep_pre_win_sel1", {6'd0, win1}, 8'd2);
    snap();
    sr1_stamp.delete();
    press(1, 40, 10);
    chk("rep_pulse_count", 8'(n_sr[1] - s_r1), 8'd5);
    for (int i = 1; i < sr1_stamp.size(); i++)
      chk("rep_spacing", 8'(sr1_stamp[i] - sr1_stamp[i-1]), 8'd8);
    chk("rep_win_sel1",   {6'd0, win1}, 8'd0);
    chk("rep_at_min1",    {7'd0, amin1}, 8'd1);
    chk("norep_count",    8'(n_sr[0] - s_r0), 8'd1);
    chk("norep_win_sel0", {6'd0, win0}, 8'd1);

    press(0, 20, 10);
    btn_right = 1'b1;
    repeat (12) tick();
    R_n = 1'b0;
    btn_right = 1'b0;
    model_reset();
    snap();
    repeat (3) tick();
    R_n = 1'b1;
    repeat (30) tick();
    chk("rst_hold_no_pulse1", 8'(n_sr[1] - s_r1 + n_sl[1] - s_l1), 8'd0);
    chk("rst_hold_no_pulse0", 8'(n_sr[0] - s_r0 + n_sl[0] - s_l0), 8'd0);
    chk("rst_hold_win_sel1",  {6'd0, win1}, 8'd0);
    chk("rst_hold_win_sel0",  {6'd0, win0}, 8'd0);

    rl = 1; rr = 1; rp = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        R_n = 1'b0; btn_left = 1'b0; btn_right = 1'b0; prod_valid = 1'b0;
        model_reset();
        repeat (3) tick();
        R_n = 1'b1;
        repeat (3) tick();
      end
      if (rl == 0) begin btn_left   = ~btn_left;   rl = pick(4, 25); end
      if (rr == 0) begin btn_right  = ~btn_right;  rr = pick(4, 25); end
      if (rp == 0) begin prod_valid = ~prod_valid; rp = int'($urandom_range(2, 40)); end
      rl--; rr--; rp--;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
